aes_inv_cipher_iter: RTL and testbench

Iterative, parametrised AES inverse-cipher engine that decrypts one 128-bit block through all NR rounds by reusing a single round datapath. It executes the AddRoundKey → InvMixColumns → InvShiftRows → InvSubBytes round grouping from a registered state. It sits between the ciphertext source and the plaintext sink, with valid/ready handshakes on both sides. Round keys are fetched each cycle, by index, from an external key-schedule store.

---
 rtl/aes_inv_cipher_iter_if.sv | 22 ++
 rtl/aes_inv_cipher_iter.sv | 143 ++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
// rtl/aes_inv_cipher_iter_if.sv - block handshakes and round-key fetch for the AES inverse cipher
// master = ciphertext source / plaintext sink / key store; slave = engine.
interface aes_inv_cipher_iter_if;
  logic           in_valid;
  logic           in_ready;
  logic [0:127]   text_in;
  logic [3:0]     rk_index;
  logic [0:127]   rk;
  logic           out_valid;
  logic           out_ready;
  logic [0:127]   text_out;

  modport master (
    output in_valid, text_in, rk, out_ready,
    input  in_ready, rk_index, out_valid, text_out
  );

  modport slave (
    input  in_valid, text_in, rk, out_ready,
    output in_ready, rk_index, out_valid, text_out
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES inverse cipher, one round per clock
// Byte n of a block is s(n%4, n/4); bits [8n:8n+7] with bit 8n as the byte MSB.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_iter_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  state_t       st, st_d;
  logic [0:127] blk, blk_d;
  logic [3:0]   r, r_d;
  logic [0:127] x_key;
  logic [0:127] round_out;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map, then GF(2^8) inversion as x^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;
    b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq  = gmul(b, b);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [0:127] inv_round(input logic [0:127] x, input logic mix);
    logic [0:127] m;
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    m = x;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = x[32*c +: 8];
        a1 = x[32*c+8 +: 8];
        a2 = x[32*c+16 +: 8];
        a3 = x[32*c+24 +: 8];
        m[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        m[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        m[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        m[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    // Row rw rotates right by rw columns.
    for (int rw = 0; rw < 4; rw++) begin
      for (int c = 0; c < 4; c++) begin
        o[8*(rw+4*c) +: 8] = inv_sbox(m[8*(rw+4*((c-rw+4)%4)) +: 8]);
      end
    end
    return o;
  endfunction

  assign x_key        = blk ^ bus.rk;
  assign round_out    = inv_round(x_key, st == ROUND);
  assign bus.text_out = blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      blk <= '0;
      r   <= '0;
    end else begin
      st  <= st_d;
      blk <= blk_d;
      r   <= r_d;
    end
  end

  always_comb begin
    st_d          = st;
    blk_d         = blk;
    r_d           = r;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_index  = '0;
    unique case (st)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          blk_d = bus.text_in;
          r_d   = NR4;
          st_d  = INIT;
        end
      end
      INIT: begin
        bus.rk_index = NR4;
        blk_d        = round_out;
        r_d          = NR4 - 4'd1;
        st_d         = ROUND;
      end
      ROUND: begin
        bus.rk_index = r;
        blk_d        = round_out;
        if (r == 4'd1) st_d = FINAL;
        else           r_d  = r - 4'd1;
      end
      FINAL: begin
        blk_d = x_key;
        st_d  = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            blk_d = bus.text_in;
            r_d   = NR4;
            st_d  = INIT;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - directed FIPS-197 decryption vectors for aes_inv_cipher_iter
// Three engines (NR=10/12/14) share clock and reset; round keys come from a bench key schedule.
module tb_aes_inv_cipher_iter;

  localparam logic [0:127] CT1     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT2     = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT3     = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] GARBAGE = 128'hdeadbeefcafef00d0123456789abcdef;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_inv_cipher_iter_if if10 ();
  aes_inv_cipher_iter_if if12 ();
  aes_inv_cipher_iter_if if14 ();

  aes_inv_cipher_iter #(.NR(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
  aes_inv_cipher_iter #(.NR(12)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(if12));
  aes_inv_cipher_iter #(.NR(14)) u_dut14 (.clk(clk), .rst_n(rst_n), .bus(if14));

  logic [0:127] rks10 [0:15];
  logic [0:127] rks12 [0:15];
  logic [0:127] rks14 [0:15];
  logic [7:0]   sbox_t [0:255];
  logic [31:0]  w [0:59];

  assign if10.rk = rks10[if10.rk_index];
  assign if12.rk = rks12[if12.rk_index];
  assign if14.rk = rks14[if14.rk_index];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box by brute-force inverse search plus the forward affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic expand(input int nk, input int nr, input logic [0:255] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [0:127] t, input logic ordy);
    case (s)
      10: begin if10.in_valid = v; if10.text_in = t; if10.out_ready = ordy; end
      12: begin if12.in_valid = v; if12.text_in = t; if12.out_ready = ordy; end
      default: begin if14.in_valid = v; if14.text_in = t; if14.out_ready = ordy; end
    endcase
  endtask

  function automatic logic ov(input int s);
    return (s == 10) ? if10.out_valid : (s == 12) ? if12.out_valid : if14.out_valid;
  endfunction
  function automatic logic ir(input int s);
    return (s == 10) ? if10.in_ready : (s == 12) ? if12.in_ready : if14.in_ready;
  endfunction
  function automatic logic [3:0] rki(input int s);
    return (s == 10) ? if10.rk_index : (s == 12) ? if12.rk_index : if14.rk_index;
  endfunction
  function automatic logic [0:127] txt(input int s);
    return (s == 10) ? if10.text_out : (s == 12) ? if12.text_out : if14.text_out;
  endfunction

  task automatic start(input int s, input logic [0:127] ct, input string tag);
    check({tag, "_idle_ready"}, 128'(ir(s)), 128'(1));
    drive(s, 1'b1, ct, 1'b0);
    @(negedge clk);
  endtask

  // Entered at the first negedge after acceptance (INIT); leaves the engine in DONE.
  task automatic process(input int s, input int nr, input logic [0:127] exp,
                         input int garbage_k, input int stall, input string tag);
    int k;
    k = 1;
    while (ov(s) !== 1'b1 && k < 40) begin
      check({tag, "_rk_index"}, 128'(rki(s)), 128'(nr + 1 - k));
      check({tag, "_busy_ready"}, 128'(ir(s)), 128'(0));
      if (k == garbage_k) drive(s, 1'b1, GARBAGE, 1'b0);
      else                drive(s, 1'b0, '0, 1'b0);
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 128'(k - 1), 128'(nr + 1));
    check({tag, "_text_out"}, txt(s), exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 128'(ov(s)), 128'(1));
      check({tag, "_stall_text"}, txt(s), exp);
      check({tag, "_stall_ready"}, 128'(ir(s)), 128'(0));
    end
  endtask

  task automatic release_out(input int s, input string tag);
    drive(s, 1'b0, '0, 1'b1);
    #1;
    check({tag, "_done_ready"}, 128'(ir(s)), 128'(1));
    @(negedge clk);
    check({tag, "_released_valid"}, 128'(ov(s)), 128'(0));
    check({tag, "_released_ready"}, 128'(ir(s)), 128'(1));
    drive(s, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(10, 1'b0, '0, 1'b0);
    drive(12, 1'b0, '0, 1'b0);
    drive(14, 1'b0, '0, 1'b0);
    build_sbox();
    expand(4, 10, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    for (int j = 0; j < 16; j++) rks10[j] = (j <= 10) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
    expand(6, 12, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    for (int j = 0; j < 16; j++) rks12[j] = (j <= 12) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
    expand(8, 14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    for (int j = 0; j < 16; j++) rks14[j] = (j <= 14) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;

    repeat (2) @(negedge clk);
    check("reset_in_ready", 128'(if10.in_ready), 128'(1));
    check("reset_out_valid", 128'(if10.out_valid), 128'(0));
    check("reset_rk_index", 128'(if10.rk_index), 128'(0));
    check("reset_text_out", if10.text_out, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    start(10, CT1, "c1");
    process(10, 10, PT, 0, 0, "c1");
    release_out(10, "c1");

    start(12, CT2, "c2");
    process(12, 12, PT, 0, 0, "c2");
    release_out(12, "c2");

    start(14, CT3, "c3");
    process(14, 14, PT, 0, 0, "c3");
    release_out(14, "c3");

    // Stall in DONE, then hand over a second block on the releasing edge; garbage offered mid-ROUND.
    start(10, CT1, "bp");
    process(10, 10, PT, 0, 5, "bp");
    drive(10, 1'b1, CT1, 1'b1);
    #1;
    check("b2b_ready", 128'(ir(10)), 128'(1));
    @(negedge clk);
    check("b2b_accepted_valid", 128'(ov(10)), 128'(0));
    process(10, 10, PT, 5, 0, "busy");
    release_out(10, "busy");

    start(10, CT1, "rst");
    drive(10, 1'b0, '0, 1'b0);
    n = 0;
    while (rki(10) != 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_r5", 128'(rki(10)), 128'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(ov(10)), 128'(0));
    check("rst_mid_in_ready", 128'(ir(10)), 128'(1));
    check("rst_mid_rk_index", 128'(rki(10)), 128'(0));
    check("rst_mid_text_out", txt(10), 128'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_out_valid", 128'(ov(10)), 128'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_after_no_valid", 128'(ov(10)), 128'(0));
    end

    start(10, CT1, "post_rst");
    process(10, 10, PT, 0, 0, "post_rst");
    release_out(10, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
